fc_spk_sched: RTL and testbench

- Spike scheduler directly upstream of the fc_nc fully-connected neuron core.
- Buffers the sparse presynaptic spike addresses of one time step from the previous layer's spike stream.
- Replays that list once per neuron into the core using the core's en_accum / spk_addr / en_activ protocol, then samples post_syn_spk.
- Emits output spike events carrying the global neuron index; tracks time steps and drives last_time_step.

---
 rtl/fc_spk_sched.sv | 162 ++++++++++++++++
 tb/tb_fc_spk_sched.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_spk_sched.sv
// Spike scheduler for fc_nc: loads one step of spike addresses, then replays them per neuron (count+4 cycles each).
// in_spk_ready is high only in LOAD; out_spk_* has no backpressure. FC_SCHED_DEDUP_EN drops repeated addresses.
module fc_spk_sched #(
  parameter int NEURON_OFFSET    = 0,
  parameter int INPUT_FRAME_SIZE = 28,
  parameter int LAYER_SIZE       = 10,
  parameter int NUM_STEPS        = 25,
  parameter int OUT_IDX_W        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_spk_valid,
  output logic                                in_spk_ready,
  input  logic [$clog2(INPUT_FRAME_SIZE)-1:0] in_spk_addr,
  input  logic                                in_spk_last,
  output logic                                en_accum,
  output logic                                en_activ,
  output logic                                last_time_step,
  output logic [$clog2(LAYER_SIZE)-1:0]       neuron,
  output logic [$clog2(INPUT_FRAME_SIZE)-1:0] spk_addr,
  input  logic                                post_syn_spk,
  output logic                                out_spk_valid,
  output logic [OUT_IDX_W-1:0]                out_spk_neuron,
  output logic                                ts_done,
  output logic                                ovf
);
  localparam int AW = $clog2(INPUT_FRAME_SIZE);
  localparam int NW = $clog2(LAYER_SIZE);
  localparam int CW = $clog2(INPUT_FRAME_SIZE + 1);
  localparam int TW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_ACCUM, S_ACTIV, S_FIRE, S_SAMPLE
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        buf_q [INPUT_FRAME_SIZE];
  logic [CW-1:0]        count_q;
  logic [AW-1:0]        idx_q;
  logic [NW-1:0]        neuron_q;
  logic [TW-1:0]        ts_q;
  logic                 ready_q;
  logic                 ovf_q;
  logic                 out_vld_q;
  logic [AW-1:0]        spk_addr_q;
  logic [OUT_IDX_W-1:0] out_neuron_q;

  logic accept;
  logic dup;
  logic full;
  logic store;
  logic last_neuron;
  logic last_ts;

  // ready_q is only ever high in LOAD, so accept implies LOAD
  assign accept      = ready_q & in_spk_valid;
  assign full        = (count_q == CW'(INPUT_FRAME_SIZE));
  assign store       = accept & ~in_spk_last & ~dup & ~full;
  assign last_neuron = (neuron_q == NW'(LAYER_SIZE - 1));
  assign last_ts     = (ts_q == TW'(NUM_STEPS - 1));

`ifdef FC_SCHED_DEDUP_EN
  logic [INPUT_FRAME_SIZE-1:0] seen_q;

  assign dup = seen_q[in_spk_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
    end else if (state_q == S_SAMPLE && last_neuron) begin
      seen_q <= '0;
    end else if (store) begin
      seen_q[in_spk_addr] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (store) begin
      buf_q[count_q[AW-1:0]] <= in_spk_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      count_q      <= '0;
      idx_q        <= '0;
      neuron_q     <= '0;
      ts_q         <= '0;
      ready_q      <= 1'b0;
      ovf_q        <= 1'b0;
      out_vld_q    <= 1'b0;
      spk_addr_q   <= '0;
      out_neuron_q <= '0;
    end else begin
      out_vld_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          ready_q <= 1'b1;
          if (store) count_q <= count_q + CW'(1);
          if (accept && !in_spk_last && !dup && full) ovf_q <= 1'b1;
          if (accept && in_spk_last) begin
            ready_q <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          idx_q <= '0;
          if (count_q != '0) begin
            spk_addr_q <= buf_q[0];
            state_q    <= S_ACCUM;
          end else begin
            state_q <= S_ACTIV;
          end
        end
        S_ACCUM: begin
          if (CW'(idx_q) == count_q - CW'(1)) begin
            spk_addr_q <= '0;
            state_q    <= S_ACTIV;
          end else begin
            idx_q      <= idx_q + AW'(1);
            spk_addr_q <= buf_q[idx_q + AW'(1)];
          end
        end
        S_ACTIV: state_q <= S_FIRE;
        S_FIRE:  state_q <= S_SAMPLE;
        S_SAMPLE: begin
          if (post_syn_spk) begin
            out_vld_q    <= 1'b1;
            out_neuron_q <= OUT_IDX_W'(NEURON_OFFSET) + OUT_IDX_W'(neuron_q);
          end
          if (!last_neuron) begin
            neuron_q <= neuron_q + NW'(1);
            state_q  <= S_START;
          end else begin
            neuron_q <= '0;
            count_q  <= '0;
            ts_q     <= last_ts ? '0 : ts_q + TW'(1);
            ready_q  <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_spk_ready   = ready_q;
  assign en_accum       = (state_q == S_START);
  assign en_activ       = (state_q == S_ACTIV);
  assign last_time_step = (state_q != S_LOAD) && last_ts;
  assign neuron         = neuron_q;
  assign spk_addr       = spk_addr_q;
  assign out_spk_valid  = out_vld_q;
  assign out_spk_neuron = out_neuron_q;
  assign ts_done        = (state_q == S_SAMPLE) && last_neuron;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_fc_spk_sched.sv
// Bench for fc_spk_sched: scoreboards replayed addresses and output spike events against a step-level model.
module tb_fc_spk_sched;
  localparam int LS   = 2;
  localparam int IFS  = 16;
  localparam int NOFF = 20;
  localparam int NS   = 2;
  localparam int OW   = 16;
  localparam int AW   = $clog2(IFS);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_spk_valid;
  logic          in_spk_ready;
  logic [AW-1:0] in_spk_addr;
  logic          in_spk_last;
  logic          en_accum;
  logic          en_activ;
  logic          last_time_step;
  logic [$clog2(LS)-1:0] neuron;
  logic [AW-1:0] spk_addr;
  logic          post_syn_spk;
  logic          out_spk_valid;
  logic [OW-1:0] out_spk_neuron;
  logic          ts_done;
  logic          ovf;

  always #5 clk = ~clk;

  fc_spk_sched #(
    .NEURON_OFFSET(NOFF), .INPUT_FRAME_SIZE(IFS), .LAYER_SIZE(LS),
    .NUM_STEPS(NS), .OUT_IDX_W(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_spk_valid(in_spk_valid), .in_spk_ready(in_spk_ready),
    .in_spk_addr(in_spk_addr), .in_spk_last(in_spk_last),
    .en_accum(en_accum), .en_activ(en_activ), .last_time_step(last_time_step),
    .neuron(neuron), .spk_addr(spk_addr), .post_syn_spk(post_syn_spk),
    .out_spk_valid(out_spk_valid), .out_spk_neuron(out_spk_neuron),
    .ts_done(ts_done), .ovf(ovf)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   stim_q[$];
  int   exp_addr_q[$];
  int   exp_evt_q[$];
  int   accum_cyc[$];
  int   activ_cyc[$];
  int   done_cyc;
  logic [1:0] fire_mask;
  int   m_ts;
  int   m_len;
  bit   m_lts;
  bit   m_ovf;

  // Expected replay list and fire events for the step in stim_q.
  task automatic model_step();
    int mbuf[$];
    int a;
`ifdef FC_SCHED_DEDUP_EN
    bit seen [IFS];
    foreach (seen[i]) seen[i] = 1'b0;
`endif
    foreach (stim_q[i]) begin
      a = stim_q[i];
`ifdef FC_SCHED_DEDUP_EN
      if (seen[a]) continue;
      seen[a] = 1'b1;
`endif
      if (mbuf.size() == IFS) m_ovf = 1'b1;
      else mbuf.push_back(a);
    end
    m_len = mbuf.size();
    m_lts = (m_ts == NS - 1);
    for (int n = 0; n < LS; n++) begin
      foreach (mbuf[i]) exp_addr_q.push_back(mbuf[i]);
      if (fire_mask[n]) exp_evt_q.push_back(NOFF + n);
    end
  endtask

  task automatic drive_load();
    int w = 0;
    while (in_spk_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (in_spk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready: in_spk_ready=%b required 1", in_spk_ready);
    end
    foreach (stim_q[i]) begin
      in_spk_valid = 1'b1;
      in_spk_addr  = AW'(stim_q[i]);
      in_spk_last  = 1'b0;
      @(negedge clk);
    end
    in_spk_valid = 1'b1;
    in_spk_addr  = '0;
    in_spk_last  = 1'b1;
    @(negedge clk);
    in_spk_valid = 1'b0;
    in_spk_last  = 1'b0;
  endtask

  task automatic observe_step();
    int cyc = 0;
    bit in_acc = 1'b0;
    int lts_hi = 0;
    int e;
    accum_cyc.delete();
    activ_cyc.delete();
    done_cyc = -1;
    while (cyc < 1000) begin
      post_syn_spk = fire_mask[neuron];
      if (last_time_step === 1'b1) lts_hi++;
      if (en_accum === 1'b1) begin
        accum_cyc.push_back(cyc);
        in_acc = 1'b1;
      end else if (en_activ === 1'b1) begin
        activ_cyc.push_back(cyc);
        in_acc = 1'b0;
      end else if (in_acc) begin
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL replay_extra: spk_addr=%0d at cycle %0d, none expected", spk_addr, cyc);
        end else begin
          e = exp_addr_q.pop_front();
          if (spk_addr !== AW'(e)) begin
            miscompares++;
            $display("FAIL replay_addr: spk_addr=%0d required %0d (cycle %0d)", spk_addr, e, cyc);
          end
        end
      end
      if (out_spk_valid === 1'b1) begin
        vectors++;
        if (exp_evt_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_spk_extra: neuron=%0d, none expected", out_spk_neuron);
        end else begin
          e = exp_evt_q.pop_front();
          if (out_spk_neuron !== OW'(e)) begin
            miscompares++;
            $display("FAIL out_spk_neuron: got %0d required %0d", out_spk_neuron, e);
          end
        end
      end
      if (done_cyc >= 0) break;
      if (ts_done === 1'b1) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL ts_done_timeout: no ts_done within %0d cycles", cyc);
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_evt_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_output: %0d replays and %0d spikes outstanding, required 0",
               exp_addr_q.size(), exp_evt_q.size());
    end
    vectors++;
    if (lts_hi != (m_lts ? LS * (m_len + 4) : 0)) begin
      miscompares++;
      $display("FAIL last_time_step: high %0d cycles, required %0d", lts_hi,
               m_lts ? LS * (m_len + 4) : 0);
    end
    vectors++;
    if (accum_cyc.size() != LS || activ_cyc.size() != LS) begin
      miscompares++;
      $display("FAIL neuron_passes: %0d en_accum / %0d en_activ, required %0d each",
               accum_cyc.size(), activ_cyc.size(), LS);
    end else begin
      for (int n = 0; n < LS; n++) begin
        vectors++;
        if (activ_cyc[n] - accum_cyc[n] - 1 != m_len) begin
          miscompares++;
          $display("FAIL accum_len: neuron %0d got %0d cycles required %0d", n,
                   activ_cyc[n] - accum_cyc[n] - 1, m_len);
        end
      end
    end
    m_ts = (m_ts == NS - 1) ? 0 : m_ts + 1;
  endtask

  task automatic run_step();
    model_step();
    drive_load();
    observe_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({in_spk_ready, en_accum, en_activ, last_time_step, neuron, spk_addr,
         out_spk_valid, out_spk_neuron, ts_done, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b accum=%b activ=%b lts=%b neuron=%0d addr=%0d vld=%b idx=%0d done=%b ovf=%b, required all 0",
               in_spk_ready, en_accum, en_activ, last_time_step, neuron, spk_addr,
               out_spk_valid, out_spk_neuron, ts_done, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_spk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready_after_reset: got %b required 1", in_spk_ready);
    end
    vectors++;
    if ({en_accum, en_activ, last_time_step, ts_done} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_controls: got %b required 0000",
               {en_accum, en_activ, last_time_step, ts_done});
    end
  endtask

  task automatic test_timing();
    stim_q.delete();
    stim_q.push_back(3);
    stim_q.push_back(7);
    fire_mask = 2'b01;
    run_step();
    if (accum_cyc.size() == LS && activ_cyc.size() == LS) begin
      vectors++;
      if (activ_cyc[0] != accum_cyc[0] + 3) begin
        miscompares++;
        $display("FAIL timing_activ: at C+%0d required C+3", activ_cyc[0] - accum_cyc[0]);
      end
      vectors++;
      if (accum_cyc[1] != accum_cyc[0] + 6) begin
        miscompares++;
        $display("FAIL timing_start2: at C+%0d required C+6", accum_cyc[1] - accum_cyc[0]);
      end
      vectors++;
      if (done_cyc != accum_cyc[0] + 11) begin
        miscompares++;
        $display("FAIL timing_ts_done: at C+%0d required C+11", done_cyc - accum_cyc[0]);
      end
    end
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b required 0", ovf);
    end
  endtask

  task automatic test_zero_spike();
    stim_q.delete();
    fire_mask = 2'b11;
    run_step();
    if (accum_cyc.size() == LS && activ_cyc.size() == LS) begin
      vectors++;
      if (activ_cyc[0] != accum_cyc[0] + 1) begin
        miscompares++;
        $display("FAIL zero_activ: at C+%0d required C+1", activ_cyc[0] - accum_cyc[0]);
      end
      vectors++;
      if (done_cyc != accum_cyc[0] + 7) begin
        miscompares++;
        $display("FAIL zero_ts_done: at C+%0d required C+7", done_cyc - accum_cyc[0]);
      end
    end
  endtask

  task automatic test_num_steps();
    for (int s = 0; s < 2; s++) begin
      stim_q.delete();
      stim_q.push_back(s + 1);
      fire_mask = 2'b10;
      run_step();
    end
    vectors++;
    if (last_time_step !== 1'b0) begin
      miscompares++;
      $display("FAIL lts_in_load: got %b required 0", last_time_step);
    end
  endtask

  task automatic test_overflow();
    stim_q.delete();
    for (int i = 0; i < IFS; i++) stim_q.push_back(i);
    stim_q.push_back(4);
    stim_q.push_back(9);
    fire_mask = 2'b01;
    run_step();
    vectors++;
    if (ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL ovf_flag: got %b required %b", ovf, m_ovf);
    end
    if (activ_cyc.size() > 0 && accum_cyc.size() > 0) begin
      vectors++;
      if (activ_cyc[0] - accum_cyc[0] - 1 != IFS) begin
        miscompares++;
        $display("FAIL ovf_replays: got %0d required %0d", activ_cyc[0] - accum_cyc[0] - 1, IFS);
      end
    end
  endtask

  task automatic test_dedup();
    int exp_len;
`ifdef FC_SCHED_DEDUP_EN
    exp_len = 2;
`else
    exp_len = 3;
`endif
    stim_q.delete();
    stim_q.push_back(5);
    stim_q.push_back(5);
    stim_q.push_back(9);
    fire_mask = 2'b00;
    run_step();
    if (activ_cyc.size() > 0 && accum_cyc.size() > 0) begin
      vectors++;
      if (activ_cyc[0] - accum_cyc[0] - 1 != exp_len) begin
        miscompares++;
        $display("FAIL dup_replays: got %0d required %0d", activ_cyc[0] - accum_cyc[0] - 1, exp_len);
      end
    end
    stim_q.delete();
    stim_q.push_back(5);
    fire_mask = 2'b11;
    run_step();
    vectors++;
    if (ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b required %b", ovf, m_ovf);
    end
  endtask

  task automatic test_rst_mid_accum();
    int n_acc = 0;
    int w = 0;
    stim_q.delete();
    stim_q.push_back(1);
    stim_q.push_back(2);
    stim_q.push_back(4);
    fire_mask = 2'b01;
    model_step();
    drive_load();
    while (n_acc < 2 && w < 200) begin
      post_syn_spk = fire_mask[neuron];
      if (en_accum === 1'b1) n_acc++;
      if (n_acc < 2) begin
        @(negedge clk);
        w++;
      end
    end
    @(negedge clk);
    vectors++;
    if (n_acc != 2 || spk_addr !== AW'(1) || neuron !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_accum_n1: starts=%0d neuron=%0d spk_addr=%0d, required 2/1/1",
               n_acc, neuron, spk_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_spk_ready, en_accum, en_activ, last_time_step, neuron, spk_addr,
         out_spk_valid, out_spk_neuron, ts_done, ovf} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ready=%b accum=%b activ=%b lts=%b neuron=%0d addr=%0d vld=%b idx=%0d done=%b ovf=%b, required all 0",
               in_spk_ready, en_accum, en_activ, last_time_step, neuron, spk_addr,
               out_spk_valid, out_spk_neuron, ts_done, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_evt_q.delete();
    m_ts  = 0;
    m_ovf = 1'b0;
    stim_q.delete();
    stim_q.push_back(6);
    fire_mask = 2'b01;
    run_step();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_after_reset: got %b required 0", ovf);
    end
  endtask

  initial begin
    in_spk_valid = 1'b0;
    in_spk_addr  = '0;
    in_spk_last  = 1'b0;
    post_syn_spk = 1'b0;
    fire_mask    = 2'b00;
    m_ts         = 0;
    m_ovf        = 1'b0;
    test_reset();
    test_timing();
    test_zero_spike();
    test_num_steps();
    test_overflow();
    test_dedup();
    test_rst_mid_accum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
